// File: rtl/text_plane_buffer.sv
// text_plane_buffer: ROWS x COLS character plane with direct writes, a
// cursor-driven put port, and clear/scroll sweeps that process one cell per clock.
module text_plane_buffer #(
  parameter int ROWS   = 7,
  parameter int COLS   = 20,
  parameter int DATA_W = 8,
  parameter int BLANK  = 129,
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [RW-1:0]     wr_row,
  input  logic [CW-1:0]     wr_col,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              put_en,
  input  logic              clear_req,
  input  logic              scroll_req,
  input  logic [RW-1:0]     rd_row,
  input  logic [CW-1:0]     rd_col,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic [RW-1:0]     cur_row,
  output logic [CW-1:0]     cur_col,
  output logic              wr_drop
);

  localparam int N  = ROWS * COLS;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [IW-1:0]     LAST_IDX  = IW'(N - 1);
  localparam logic [IW-1:0]     COPY_LAST = (ROWS > 1) ? IW'((ROWS - 1) * COLS - 1) : '0;
  localparam logic [IW-1:0]     COLS_I    = IW'(COLS);
  localparam logic [RW-1:0]     LAST_ROW  = RW'(ROWS - 1);
  localparam logic [CW-1:0]     LAST_COL  = CW'(COLS - 1);
  localparam logic [DATA_W-1:0] BLANK_C   = DATA_W'(BLANK);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    SCROLL_COPY,
    SCROLL_FILL
  } state_t;

  // With a single row there is nothing to copy, so a scroll is only the fill pass.
  localparam state_t SCROLL_START = (ROWS == 1) ? SCROLL_FILL : SCROLL_COPY;

  state_t state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [RW-1:0]     curRow_q, curRow_d;
  logic [CW-1:0]     curCol_q, curCol_d;
  logic [DATA_W-1:0] rdData_q, rdData_d;
  logic              wrDrop_q, wrDrop_d;

  logic              memWe;
  logic [IW-1:0]     memWaddr;
  logic [DATA_W-1:0] memWdata;
  logic [DATA_W-1:0] wrValue;
  logic [DATA_W-1:0] mem_q [N];

  function automatic logic [IW-1:0] cellIndex(input logic [RW-1:0] r, input logic [CW-1:0] c);
    return IW'(r) * COLS_I + IW'(c);
  endfunction

  // The all-ones code is an erase request and is stored as the blank code.
  assign wrValue = (&wr_data) ? BLANK_C : wr_data;

  // Read port: addresses outside the plane read as blank.
  always_comb begin
    rdData_d = BLANK_C;
    if (rd_row <= LAST_ROW && rd_col <= LAST_COL) begin
      rdData_d = mem_q[cellIndex(rd_row, rd_col)];
    end
  end

  // Next-state logic: request priority in IDLE, one-cell-per-clock sweeps otherwise.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    curRow_d = curRow_q;
    curCol_d = curCol_q;
    wrDrop_d = 1'b0;
    memWe    = 1'b0;
    memWaddr = idx_q;
    memWdata = BLANK_C;
    case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d  = CLEAR;
          idx_d    = '0;
          curRow_d = '0;
          curCol_d = '0;
        end else if (scroll_req) begin
          state_d = SCROLL_START;
          idx_d   = '0;
        end else if (put_en) begin
          memWe    = 1'b1;
          memWaddr = cellIndex(curRow_q, curCol_q);
          memWdata = wrValue;
          if (curCol_q != LAST_COL) begin
            curCol_d = curCol_q + CW'(1);
          end else if (curRow_q != LAST_ROW) begin
            curRow_d = curRow_q + RW'(1);
            curCol_d = '0;
          end else begin
            curCol_d = '0;
            state_d  = SCROLL_START;
            idx_d    = '0;
          end
        end else if (wr_en) begin
          if (wr_row <= LAST_ROW && wr_col <= LAST_COL) begin
            memWe    = 1'b1;
            memWaddr = cellIndex(wr_row, wr_col);
            memWdata = wrValue;
          end
        end
      end
      CLEAR, SCROLL_FILL: begin
        wrDrop_d = wr_en | put_en;
        memWe    = 1'b1;
        memWdata = BLANK_C;
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      SCROLL_COPY: begin
        wrDrop_d = wr_en | put_en;
        memWe    = 1'b1;
        memWdata = mem_q[idx_q + COLS_I];
        idx_d    = idx_q + IW'(1);
        if (idx_q == COPY_LAST) begin
          state_d = SCROLL_FILL;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control registers; reset restarts the clear sweep from the first cell.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= CLEAR;
      idx_q    <= '0;
      curRow_q <= '0;
      curCol_q <= '0;
      rdData_q <= BLANK_C;
      wrDrop_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      curRow_q <= curRow_d;
      curCol_q <= curCol_d;
      rdData_q <= rdData_d;
      wrDrop_q <= wrDrop_d;
    end
  end

  // Cell storage: one write per clock, suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (!reset && memWe) begin
      mem_q[memWaddr] <= memWdata;
    end
  end

  assign rd_data = rdData_q;
  assign busy    = (state_q != IDLE);
  assign cur_row = curRow_q;
  assign cur_col = curCol_q;
  assign wr_drop = wrDrop_q;

endmodule

// File: tb/tb_text_plane_buffer.sv
// tb_text_plane_buffer: table-driven vectors for writes, reads and puts,
// plus hand-written sequences for the clear, scroll and reset sweeps.
module tb_text_plane_buffer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [2:0] wr_row = '0;
  logic [4:0] wr_col = '0;
  logic [7:0] wr_data = '0;
  logic       put_en = 1'b0;
  logic       clear_req = 1'b0;
  logic       scroll_req = 1'b0;
  logic [2:0] rd_row = '0;
  logic [4:0] rd_col = '0;
  logic [7:0] rd_data;
  logic       busy;
  logic [2:0] cur_row;
  logic [4:0] cur_col;
  logic       wr_drop;

  int compared = 0;
  int mismatched = 0;

  text_plane_buffer dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_row    (wr_row),
    .wr_col    (wr_col),
    .wr_data   (wr_data),
    .put_en    (put_en),
    .clear_req (clear_req),
    .scroll_req(scroll_req),
    .rd_row    (rd_row),
    .rd_col    (rd_col),
    .rd_data   (rd_data),
    .busy      (busy),
    .cur_row   (cur_row),
    .cur_col   (cur_col),
    .wr_drop   (wr_drop)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       wr;
    logic       put;
    logic [2:0] row;
    logic [4:0] col;
    logic [7:0] data;
    logic [2:0] rRow;
    logic [4:0] rCol;
    logic [7:0] expRd;
    logic [2:0] expCurRow;
    logic [4:0] expCurCol;
  } vec_t;

  vec_t vecs[$];

  function automatic void addVec(string name, logic wr, logic put, int row, int col, int data,
                                 int rRow, int rCol, int expRd, int expCurRow, int expCurCol);
    vec_t v;
    v.name = name; v.wr = wr; v.put = put;
    v.row = 3'(row); v.col = 5'(col); v.data = 8'(data);
    v.rRow = 3'(rRow); v.rCol = 5'(rCol); v.expRd = 8'(expRd);
    v.expCurRow = 3'(expCurRow); v.expCurCol = 5'(expCurCol);
    vecs.push_back(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic readCell(input int r, input int c, output logic [7:0] d);
    rd_row = 3'(r);
    rd_col = 5'(c);
    tick();
    d = rd_data;
  endtask

  task automatic waitIdle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 300) begin
      tick();
      n++;
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    wr_en   = v.wr;
    put_en  = v.put;
    wr_row  = v.row;
    wr_col  = v.col;
    wr_data = v.data;
    rd_row  = v.rRow;
    rd_col  = v.rCol;
    tick();
    wr_en  = 1'b0;
    put_en = 1'b0;
  endtask

  initial begin
    int n;
    logic [7:0] d;

    // Direct writes, erase, out-of-range handling.
    addVec("wr41",     1, 0, 2, 5,  8'h41, 2, 5,  129,   0, 0);
    addVec("rd41",     0, 0, 0, 0,  0,     2, 5,  8'h41, 0, 0);
    addVec("erase",    1, 0, 2, 5,  8'hFF, 2, 5,  8'h41, 0, 0);
    addVec("rdErase",  0, 0, 0, 0,  0,     2, 5,  129,   0, 0);
    addVec("wrRowOOR", 1, 0, 7, 0,  8'h12, 7, 0,  129,   0, 0);
    addVec("wrColOOR", 1, 0, 0, 20, 8'h13, 0, 20, 129,   0, 0);
    addVec("wrCorner", 1, 0, 6, 19, 8'h66, 1, 0,  129,   0, 0);
    // Twenty puts from (0,0) wrap onto row 1.
    for (int k = 0; k < 20; k++) begin
      addVec($sformatf("put%0d", k), 0, 1, 0, 0, 8'h30 + k, 0, 19, 129,
             (k == 19) ? 1 : 0, (k == 19) ? 0 : k + 1);
    end
    addVec("rdWrap",   0, 0, 0, 0,  0,     0, 19, 8'h43, 1, 0);
    addVec("rdFirst",  0, 0, 0, 0,  0,     0, 0,  8'h30, 1, 0);
    addVec("rdCorner", 0, 0, 0, 0,  0,     6, 19, 8'h66, 1, 0);
    // Put wins over a simultaneous direct write.
    addVec("wrPut",    1, 1, 3, 3,  8'h55, 3, 3,  129,   1, 1);
    addVec("rdLost",   0, 0, 0, 0,  0,     3, 3,  129,   1, 1);
    addVec("rdPut",    0, 0, 0, 0,  0,     1, 0,  8'h55, 1, 1);

    // Reset and the power-on clear sweep.
    reset = 1'b1;
    tick();
    tick();
    checkOutput("rstBusy", busy, 1);
    checkOutput("rstRdData", rd_data, 129);
    checkOutput("rstDrop", wr_drop, 0);
    checkOutput("rstCurRow", cur_row, 0);
    checkOutput("rstCurCol", cur_col, 0);
    reset = 1'b0;
    waitIdle(n);
    checkOutput("rstCycles", n, 140);
    readCell(3, 7, d);
    checkOutput("rstRead37", d, 129);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput({vecs[i].name, "_rd"}, rd_data, vecs[i].expRd);
      checkOutput({vecs[i].name, "_row"}, cur_row, vecs[i].expCurRow);
      checkOutput({vecs[i].name, "_col"}, cur_col, vecs[i].expCurCol);
      checkOutput({vecs[i].name, "_drop"}, wr_drop, 0);
      checkOutput({vecs[i].name, "_busy"}, busy, 0);
    end

    // Explicit scroll with dropped write/put and ignored requests mid-sweep.
    scroll_req = 1'b1;
    tick();
    scroll_req = 1'b0;
    checkOutput("scrollBusy", busy, 1);
    n = 0;
    while (busy === 1'b1 && n < 300) begin
      wr_en      = (n == 100);
      put_en     = (n == 101);
      clear_req  = (n == 102);
      scroll_req = (n == 103);
      wr_row     = 3'd0;
      wr_col     = 5'd0;
      wr_data    = 8'h77;
      tick();
      n++;
      if (n == 101) checkOutput("dropWr", wr_drop, 1);
      if (n == 102) checkOutput("dropPut", wr_drop, 1);
      if (n == 103) checkOutput("noDropReq", wr_drop, 0);
    end
    wr_en = 1'b0; put_en = 1'b0; clear_req = 1'b0; scroll_req = 1'b0;
    checkOutput("scrollCycles", n, 140);
    checkOutput("scrollCurRow", cur_row, 1);
    checkOutput("scrollCurCol", cur_col, 1);
    readCell(0, 0, d);  checkOutput("scroll00", d, 8'h55);
    readCell(5, 19, d); checkOutput("scroll519", d, 8'h66);
    readCell(6, 19, d); checkOutput("scroll619", d, 129);
    readCell(1, 0, d);  checkOutput("scroll10", d, 129);
    readCell(1, 1, d);  checkOutput("scrollPutDropped", d, 129);

    // Clear and scroll requested together: only the clear runs.
    clear_req = 1'b1;
    scroll_req = 1'b1;
    tick();
    clear_req = 1'b0;
    scroll_req = 1'b0;
    checkOutput("bothBusy", busy, 1);
    waitIdle(n);
    checkOutput("bothCycles", n, 140);
    checkOutput("bothCurRow", cur_row, 0);
    checkOutput("bothCurCol", cur_col, 0);
    readCell(0, 0, d);  checkOutput("both00", d, 129);
    readCell(5, 19, d); checkOutput("both519", d, 129);
    readCell(4, 19, d); checkOutput("both419", d, 129);

    // Auto-scroll when a put lands on the last cell.
    wr_data = 8'h01;
    put_en = 1'b1;
    for (int k = 0; k < 139; k++) tick();
    put_en = 1'b0;
    checkOutput("preAutoRow", cur_row, 6);
    checkOutput("preAutoCol", cur_col, 19);
    wr_data = 8'h5A;
    put_en = 1'b1;
    tick();
    put_en = 1'b0;
    checkOutput("autoCurRow", cur_row, 6);
    checkOutput("autoCurCol", cur_col, 0);
    checkOutput("autoBusy", busy, 1);
    waitIdle(n);
    checkOutput("autoCycles", n, 140);
    readCell(5, 19, d); checkOutput("auto519", d, 8'h5A);
    readCell(5, 18, d); checkOutput("auto518", d, 8'h01);
    readCell(6, 19, d); checkOutput("auto619", d, 129);
    readCell(0, 0, d);  checkOutput("auto00", d, 8'h01);
    checkOutput("autoCurRowAfter", cur_row, 6);

    // Reset in the middle of a clear sweep restarts it from the first cell.
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int k = 0; k < 50; k++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("midRstBusy", busy, 1);
    waitIdle(n);
    checkOutput("midRstCycles", n, 140);
    readCell(5, 18, d); checkOutput("midRst518", d, 129);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
